// File: rtl/dpram_access_arbiter.sv
// Round-robin arbiter sharing a synchronous dual-port RAM among four requesters.
// Port 0 carries the single write per cycle; port 1 only ever reads.
module dpram_access_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REQ-1:0]            o_rvalid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] o_rdata,
  output logic                          o_ram_cs_0,
  output logic                          o_ram_wr_0,
  output logic                          o_ram_oe_0,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr_0,
  output logic [DATA_WIDTH-1:0]         o_ram_wdata_0,
  input  logic [DATA_WIDTH-1:0]         i_ram_rdata_0,
  output logic                          o_ram_cs_1,
  output logic                          o_ram_wr_1,
  output logic                          o_ram_oe_1,
  output logic [ADDR_WIDTH-1:0]         o_ram_addr_1,
  output logic [DATA_WIDTH-1:0]         o_ram_wdata_1,
  input  logic [DATA_WIDTH-1:0]         i_ram_rdata_1
);

  localparam int IW = $clog2(NUM_REQ);

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_REQ];

  logic [IW-1:0]         r_ptr;
  logic [IW-1:0]         w_scanIdx;
  logic                  w_foundA;
  logic                  w_foundB;
  logic [IW-1:0]         w_idxA;
  logic [IW-1:0]         w_idxB;
  logic [IW-1:0]         w_p0Idx;
  logic [IW-1:0]         w_p1Idx;
  logic                  w_bIsWrite;

  logic                  r_cs0, r_wr0, r_oe0, r_cs1, r_oe1;
  logic [ADDR_WIDTH-1:0] r_addr0, r_addr1;
  logic [DATA_WIDTH-1:0] r_wdata0;

  logic                  r_tag0V1, r_tag0V2, r_tag1V1, r_tag1V2;
  logic [IW-1:0]         r_tag0Id1, r_tag0Id2, r_tag1Id1, r_tag1Id2;
  logic [DATA_WIDTH-1:0] r_rdataHold [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g]  = i_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = i_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // A is the first requester from the pointer; B is the first later one that
  // neither hits A's address nor pairs a second write with A's write.
  always_comb begin
    w_scanIdx = '0;
    w_foundA  = 1'b0;
    w_foundB  = 1'b0;
    w_idxA    = '0;
    w_idxB    = '0;
    o_gnt     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scanIdx = r_ptr + IW'(k);
      if (i_req[w_scanIdx]) begin
        if (!w_foundA) begin
          w_foundA = 1'b1;
          w_idxA   = w_scanIdx;
        end else if (!w_foundB && (w_addr[w_scanIdx] != w_addr[w_idxA]) &&
                     !(i_we[w_scanIdx] && i_we[w_idxA])) begin
          w_foundB = 1'b1;
          w_idxB   = w_scanIdx;
        end
      end
    end
    if (i_rst_n) begin
      if (w_foundA) o_gnt[w_idxA] = 1'b1;
      if (w_foundB) o_gnt[w_idxB] = 1'b1;
    end
  end

  assign w_bIsWrite = w_foundB && i_we[w_idxB];
  assign w_p0Idx    = w_bIsWrite ? w_idxB : w_idxA;
  assign w_p1Idx    = w_bIsWrite ? w_idxA : w_idxB;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr     <= '0;
      r_cs0     <= 1'b0;
      r_wr0     <= 1'b0;
      r_oe0     <= 1'b0;
      r_addr0   <= '0;
      r_wdata0  <= '0;
      r_cs1     <= 1'b0;
      r_oe1     <= 1'b0;
      r_addr1   <= '0;
      r_tag0V1  <= 1'b0;
      r_tag0V2  <= 1'b0;
      r_tag1V1  <= 1'b0;
      r_tag1V2  <= 1'b0;
      r_tag0Id1 <= '0;
      r_tag0Id2 <= '0;
      r_tag1Id1 <= '0;
      r_tag1Id2 <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_rdataHold[i] <= '0;
    end else begin
      if (w_foundA) r_ptr <= (w_foundB ? w_idxB : w_idxA) + IW'(1);

      r_cs0    <= w_foundA;
      r_wr0    <= w_foundA && i_we[w_p0Idx];
      r_oe0    <= w_foundA && !i_we[w_p0Idx];
      r_addr0  <= w_foundA ? w_addr[w_p0Idx] : '0;
      r_wdata0 <= (w_foundA && i_we[w_p0Idx]) ? w_wdata[w_p0Idx] : '0;
      r_cs1    <= w_foundB;
      r_oe1    <= w_foundB;
      r_addr1  <= w_foundB ? w_addr[w_p1Idx] : '0;

      // Stage 1 tracks the issue cycle, stage 2 the cycle RAM data appears.
      r_tag0V1  <= w_foundA && !i_we[w_p0Idx];
      r_tag0Id1 <= w_p0Idx;
      r_tag0V2  <= r_tag0V1;
      r_tag0Id2 <= r_tag0Id1;
      r_tag1V1  <= w_foundB;
      r_tag1Id1 <= w_p1Idx;
      r_tag1V2  <= r_tag1V1;
      r_tag1Id2 <= r_tag1Id1;

      for (int i = 0; i < NUM_REQ; i++)
        if (o_rvalid[i]) r_rdataHold[i] <= o_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    o_rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) o_rdata[i*DATA_WIDTH +: DATA_WIDTH] = r_rdataHold[i];
    if (r_tag0V2) begin
      o_rvalid[r_tag0Id2] = 1'b1;
      o_rdata[r_tag0Id2*DATA_WIDTH +: DATA_WIDTH] = i_ram_rdata_0;
    end
    if (r_tag1V2) begin
      o_rvalid[r_tag1Id2] = 1'b1;
      o_rdata[r_tag1Id2*DATA_WIDTH +: DATA_WIDTH] = i_ram_rdata_1;
    end
  end

  assign o_ram_cs_0    = r_cs0;
  assign o_ram_wr_0    = r_wr0;
  assign o_ram_oe_0    = r_oe0;
  assign o_ram_addr_0  = r_addr0;
  assign o_ram_wdata_0 = r_wdata0;
  assign o_ram_cs_1    = r_cs1;
  assign o_ram_wr_1    = 1'b0;
  assign o_ram_oe_1    = r_oe1;
  assign o_ram_addr_1  = r_addr1;
  assign o_ram_wdata_1 = '0;

endmodule
